// File: rtl/cond_pkg.sv
// Shared constants for conditional execution: ARM condition codes, flag bit
// positions inside {N,Z,C,V}, and the meaning of each FlagW bit.
package cond_pkg;

    localparam logic [3:0] COND_EQ = 4'b0000;
    localparam logic [3:0] COND_NE = 4'b0001;
    localparam logic [3:0] COND_CS = 4'b0010;
    localparam logic [3:0] COND_CC = 4'b0011;
    localparam logic [3:0] COND_MI = 4'b0100;
    localparam logic [3:0] COND_PL = 4'b0101;
    localparam logic [3:0] COND_VS = 4'b0110;
    localparam logic [3:0] COND_VC = 4'b0111;
    localparam logic [3:0] COND_HI = 4'b1000;
    localparam logic [3:0] COND_LS = 4'b1001;
    localparam logic [3:0] COND_GE = 4'b1010;
    localparam logic [3:0] COND_LT = 4'b1011;
    localparam logic [3:0] COND_GT = 4'b1100;
    localparam logic [3:0] COND_LE = 4'b1101;
    localparam logic [3:0] COND_AL = 4'b1110;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    localparam int FLAGW_NZ = 1;
    localparam int FLAGW_CV = 0;

    localparam logic [3:0] FLAGS_RESET = 4'b0000;

endpackage

// File: rtl/cond_logic_if.sv
// Decoder-side bundle for the conditional-execution unit: write requests and
// ALU flags in, gated strobes and the architectural flags out.
interface cond_logic_if;

    logic       En;
    logic [3:0] Cond;
    logic [3:0] ALUFlags;
    logic [1:0] FlagW;
    logic       NoWrite;
    logic       PCS;
    logic       RegW;
    logic       MemW;
    logic       PCSrc;
    logic       RegWrite;
    logic       MemWrite;
    logic       CondEx;
    logic [3:0] Flags;

    modport master (
        output En, Cond, ALUFlags, FlagW, NoWrite, PCS, RegW, MemW,
        input  PCSrc, RegWrite, MemWrite, CondEx, Flags
    );

    modport slave (
        input  En, Cond, ALUFlags, FlagW, NoWrite, PCS, RegW, MemW,
        output PCSrc, RegWrite, MemWrite, CondEx, Flags
    );

endinterface

// File: rtl/cond_check.sv
// Pure combinational evaluation of a 4-bit ARM condition field against the
// stored {N,Z,C,V} flags.
module cond_check
    import cond_pkg::*;
(
    input  logic [3:0] cond,
    input  logic [3:0] flags,
    output logic       cond_ex
);

    logic n, z, c, v;

    assign n = flags[FLAG_N];
    assign z = flags[FLAG_Z];
    assign c = flags[FLAG_C];
    assign v = flags[FLAG_V];

    always_comb begin
        // NOTE: default assignment first so every path drives cond_ex and no latch is inferred.
        cond_ex = 1'b1;
        case (cond)
            COND_EQ: cond_ex = z;
            COND_NE: cond_ex = ~z;
            COND_CS: cond_ex = c;
            COND_CC: cond_ex = ~c;
            COND_MI: cond_ex = n;
            COND_PL: cond_ex = ~n;
            COND_VS: cond_ex = v;
            COND_VC: cond_ex = ~v;
            COND_HI: cond_ex = c & ~z;
            COND_LS: cond_ex = ~c | z;
            COND_GE: cond_ex = (n == v);
            COND_LT: cond_ex = (n != v);
            COND_GT: cond_ex = ~z & (n == v);
            COND_LE: cond_ex = z | (n != v);
            // AL and the unused 1111 encoding both always execute.
            default: cond_ex = 1'b1;
        endcase
    end

endmodule

// File: rtl/cond_logic.sv
// Conditional-execution unit: holds the NZCV flag register, checks the
// instruction's condition against it and gates the decoder's write strobes.
module cond_logic
    import cond_pkg::*;
(
    input  logic         clk,
    input  logic         reset_n,
    cond_logic_if.slave  bus
);

    logic [3:0] flags_q;
    logic [3:0] flags_d;
    logic       cond_ex;
    logic       commit;

    // Condition sees only the registered flags, so a flag-setting instruction
    // affects the next instruction and never itself.
    cond_check u_cond_check (
        .cond    (bus.Cond),
        .flags   (flags_q),
        .cond_ex (cond_ex)
    );

    assign commit = bus.En & cond_ex;

    always_comb begin
        flags_d = flags_q;
        if (commit) begin
            if (bus.FlagW[FLAGW_NZ]) begin
                flags_d[FLAG_N] = bus.ALUFlags[FLAG_N];
                flags_d[FLAG_Z] = bus.ALUFlags[FLAG_Z];
            end
            if (bus.FlagW[FLAGW_CV]) begin
                flags_d[FLAG_C] = bus.ALUFlags[FLAG_C];
                flags_d[FLAG_V] = bus.ALUFlags[FLAG_V];
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            flags_q <= FLAGS_RESET;
        end else begin
            // NOTE: non-blocking assignment for state so every flop samples pre-edge values.
            flags_q <= flags_d;
        end
    end

    assign bus.CondEx   = cond_ex;
    assign bus.PCSrc    = bus.PCS  & commit;
    assign bus.RegWrite = bus.RegW & commit & ~bus.NoWrite;
    assign bus.MemWrite = bus.MemW & commit;
    assign bus.Flags    = flags_q;

endmodule

// File: tb/tb_cond_logic.sv
// Scoreboard bench for cond_logic: the driver pushes expected responses, a
// monitor on the falling edge pops and compares them against the DUT.
module tb_cond_logic;

    typedef struct packed {
        logic       cond_ex;
        logic       pc_src;
        logic       reg_write;
        logic       mem_write;
        logic [3:0] flags;
    } resp_t;

    logic clk = 1'b0;
    logic reset_n = 1'b0;

    cond_logic_if bus ();

    cond_logic dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    resp_t exp_q[$];
    int    checks = 0;
    int    errors = 0;
    int    txn_id = 0;
    logic [3:0] model_flags = 4'b0000;

    // ARM rule: codes pair up, the odd code of each pair is the negation of the even one.
    function automatic bit cond_holds(input logic [3:0] c, input logic [3:0] f);
        bit n, z, cf, v, base;
        n = f[3]; z = f[2]; cf = f[1]; v = f[0];
        if (c[3:1] == 3'b111) return 1'b1;
        case (c[3:1])
            3'd0:    base = z;
            3'd1:    base = cf;
            3'd2:    base = n;
            3'd3:    base = v;
            3'd4:    base = cf && !z;
            3'd5:    base = (n == v);
            default: base = !z && (n == v);
        endcase
        return c[0] ? !base : base;
    endfunction

    task automatic check(input string name, input resp_t got, input resp_t exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got condex=%b pcsrc=%b regwrite=%b memwrite=%b flags=%b expected condex=%b pcsrc=%b regwrite=%b memwrite=%b flags=%b",
                     name, got.cond_ex, got.pc_src, got.reg_write, got.mem_write, got.flags,
                     exp.cond_ex, exp.pc_src, exp.reg_write, exp.mem_write, exp.flags);
        end
    endtask

    // Applies one cycle of stimulus just after the rising edge, queues the
    // expected response (explicit or model-derived) and advances the model.
    task automatic step(input bit rst, input bit en, input logic [3:0] cond,
                        input logic [3:0] aluf, input logic [1:0] flagw,
                        input bit nowrite, input bit pcs, input bit regw, input bit memw,
                        input bit use_exp, input resp_t exp_in);
        resp_t e;
        bit ok;
        @(posedge clk);
        #1;
        reset_n      = rst;
        bus.En       = en;
        bus.Cond     = cond;
        bus.ALUFlags = aluf;
        bus.FlagW    = flagw;
        bus.NoWrite  = nowrite;
        bus.PCS      = pcs;
        bus.RegW     = regw;
        bus.MemW     = memw;
        if (!rst) model_flags = 4'b0000;
        ok = cond_holds(cond, model_flags);
        e.cond_ex   = ok;
        e.pc_src    = pcs && ok && en;
        e.reg_write = regw && ok && !nowrite && en;
        e.mem_write = memw && ok && en;
        e.flags     = model_flags;
        exp_q.push_back(use_exp ? exp_in : e);
        if (rst && en && ok) begin
            if (flagw[1]) model_flags[3:2] = aluf[3:2];
            if (flagw[0]) model_flags[1:0] = aluf[1:0];
        end
    endtask

    function automatic resp_t r(input bit ce, input bit ps, input bit rw, input bit mw,
                                input logic [3:0] f);
        resp_t x;
        x.cond_ex = ce; x.pc_src = ps; x.reg_write = rw; x.mem_write = mw; x.flags = f;
        return x;
    endfunction

    // Monitor: compares whatever response is outstanding on each falling edge.
    initial begin
        resp_t got, exp;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                exp = exp_q.pop_front();
                got = {bus.CondEx, bus.PCSrc, bus.RegWrite, bus.MemWrite, bus.Flags};
                check($sformatf("txn%0d", txn_id), got, exp);
                txn_id++;
            end
        end
    end

    initial begin
        resp_t nx;
        nx = '0;
        bus.En = 1'b0; bus.Cond = 4'b0; bus.ALUFlags = 4'b0; bus.FlagW = 2'b0;
        bus.NoWrite = 1'b0; bus.PCS = 1'b0; bus.RegW = 1'b0; bus.MemW = 1'b0;

        // Reset with a flag-setting instruction pending, then release.
        step(0, 1, 4'hE, 4'hF, 2'b11, 0, 0, 0, 0, 1, r(1, 0, 0, 0, 4'b0000));
        step(1, 1, 4'h0, 4'hF, 2'b00, 0, 0, 0, 0, 1, r(0, 0, 0, 0, 4'b0000));
        step(1, 1, 4'h1, 4'hF, 2'b00, 0, 0, 0, 0, 1, r(1, 0, 0, 0, 4'b0000));

        // Independent NZ / CV halves.
        step(1, 1, 4'hE, 4'hF, 2'b10, 0, 0, 0, 0, 1, r(1, 0, 0, 0, 4'b0000));
        step(1, 1, 4'hE, 4'h0, 2'b01, 0, 0, 0, 0, 1, r(1, 0, 0, 0, 4'b1100));
        step(1, 1, 4'hE, 4'h3, 2'b01, 0, 0, 0, 0, 1, r(1, 0, 0, 0, 4'b1100));
        step(1, 1, 4'hE, 4'h0, 2'b00, 0, 0, 0, 0, 1, r(1, 0, 0, 0, 4'b1111));

        // CMP: register write suppressed, flags land one cycle later.
        step(1, 1, 4'hE, 4'h6, 2'b11, 1, 0, 1, 0, 1, r(1, 0, 0, 0, 4'b1111));
        step(1, 1, 4'h0, 4'h0, 2'b00, 0, 0, 0, 0, 1, r(1, 0, 0, 0, 4'b0110));
        step(1, 1, 4'h8, 4'h0, 2'b00, 0, 0, 0, 0, 1, r(0, 0, 0, 0, 4'b0110));

        // Failed condition blocks strobes and flag writes.
        step(0, 1, 4'hE, 4'hF, 2'b11, 0, 0, 0, 0, 1, r(1, 0, 0, 0, 4'b0000));
        step(1, 1, 4'h0, 4'hF, 2'b11, 0, 1, 1, 1, 1, r(0, 0, 0, 0, 4'b0000));
        step(1, 1, 4'hE, 4'h0, 2'b00, 0, 0, 0, 0, 1, r(1, 0, 0, 0, 4'b0000));

        // Signed-compare spot checks.
        step(1, 1, 4'hE, 4'h8, 2'b11, 0, 0, 0, 0, 1, r(1, 0, 0, 0, 4'b0000));
        step(1, 1, 4'hA, 4'h0, 2'b00, 0, 0, 0, 0, 1, r(0, 0, 0, 0, 4'b1000));
        step(1, 1, 4'hB, 4'h0, 2'b00, 0, 0, 0, 0, 1, r(1, 0, 0, 0, 4'b1000));
        step(1, 1, 4'hD, 4'h0, 2'b00, 0, 0, 0, 0, 1, r(1, 0, 0, 0, 4'b1000));
        step(1, 1, 4'hE, 4'h9, 2'b11, 0, 0, 0, 0, 1, r(1, 0, 0, 0, 4'b1000));
        step(1, 1, 4'hC, 4'h0, 2'b00, 0, 0, 0, 0, 1, r(1, 0, 0, 0, 4'b1001));

        // Stall holds flags and strobes, then the instruction commits.
        for (int i = 0; i < 3; i++)
            step(1, 0, 4'hE, 4'hA, 2'b11, 0, 0, 1, 0, 1, r(1, 0, 0, 0, 4'b1001));
        step(1, 1, 4'hE, 4'hA, 2'b11, 0, 0, 1, 0, 1, r(1, 0, 1, 0, 4'b1001));
        step(1, 1, 4'hE, 4'h0, 2'b00, 0, 0, 0, 0, 1, r(1, 0, 0, 0, 4'b1010));

        // Full Flags x Cond sweep with random write requests.
        for (int f = 0; f < 16; f++) begin
            step(1, 1, 4'hE, 4'(f), 2'b11, 0, 0, 0, 0, 0, nx);
            for (int c = 0; c < 16; c++)
                step(1, 1, 4'(c), 4'($urandom), 2'b00, 1'($urandom), 1'($urandom),
                     1'($urandom), 1'($urandom), 0, nx);
        end

        // Fully random traffic with occasional resets and stalls.
        for (int i = 0; i < 2000; i++)
            step(($urandom_range(63) != 0), ($urandom_range(7) != 0), 4'($urandom),
                 4'($urandom), 2'($urandom), 1'($urandom), 1'($urandom),
                 1'($urandom), 1'($urandom), 0, nx);

        for (int i = 0; i < 4 && exp_q.size() > 0; i++) @(negedge clk);
        if (exp_q.size() > 0) begin
            errors++;
            $display("FAIL drain got %0d pending responses expected 0", exp_q.size());
        end
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/cond_logic.md
# cond_logic

Conditional-execution unit for the single-cycle processor. Holds the architectural N/Z/C/V flag register, evaluates the 4-bit ARM condition field of the current instruction against the stored flags, and gates the decoder's write enables. Sits between the main/ALU decoder outputs (PCS, RegW, MemW, FlagW, NoWrite) and the datapath write strobes. It consumes the FlagW/NoWrite encoding that the ALU decoder produces.

## Interface
Parameters:
- none; flag bit positions and condition encodings are fixed constants (see Structure).

Ports:
- clk  input  1  processor clock; all state updates on rising edge
- reset_n  input  1  asynchronous, active-low reset
- En  input  1  instruction-valid/advance; 0 = stall, nothing commits
- Cond  input  4  instruction bits [31:28]
- ALUFlags  input  4  {N,Z,C,V} from ALU, current cycle
- FlagW  input  2  [1] = update N,Z; [0] = update C,V
- NoWrite  input  1  suppress register write (CMP)
- PCS  input  1  PC-write request from decoder
- RegW  input  1  register-write request from decoder
- MemW  input  1  memory-write request from decoder
- PCSrc  output  1  gated PC write
- RegWrite  output  1  gated register write
- MemWrite  output  1  gated memory write
- CondEx  output  1  condition passed, current instruction
- Flags  output  4  registered {N,Z,C,V}

## Operation
- Flags register (4 bits); reset value 4'b0000.
- CondEx evaluated combinationally from Cond and registered Flags (never from ALUFlags):
  - 0000 EQ Z; 0001 NE !Z; 0010 CS C; 0011 CC !C; 0100 MI N; 0101 PL !N; 0110 VS V; 0111 VC !V
  - 1000 HI C&!Z; 1001 LS !C|Z; 1010 GE N==V; 1011 LT N!=V; 1100 GT !Z&(N==V); 1101 LE Z|(N!=V); 1110 AL 1
  - 1111 treated as AL (CondEx=1).
- Gated outputs (combinational):
  - PCSrc = PCS & CondEx & En
  - RegWrite = RegW & CondEx & !NoWrite & En
  - MemWrite = MemW & CondEx & En
- Flag update at rising clk when En & CondEx:
  - FlagW[1]=1: Flags[3:2] <= ALUFlags[3:2]
  - FlagW[0]=1: Flags[1:0] <= ALUFlags[1:0]
  - halves independent; FlagW=00 holds all flags.
- Failed condition (CondEx=0): no flag update, all gated strobes 0, regardless of FlagW/NoWrite.
- En=0: flags hold, all gated strobes 0; CondEx still reflects Cond vs Flags.
- A flag-setting instruction's new flags are visible to CondEx of the next instruction only (no same-cycle forwarding).

## Timing
- Combinational path Cond/Flags -> CondEx -> strobes; zero latency, same cycle.
- Flag write: 1-cycle latency; new Flags visible after the rising edge.
- reset_n low: Flags=0000 immediately (asynchronous); outputs follow combinationally (CondEx per Cond vs 0000, e.g. EQ=0, NE=1). A reset that arrives mid-cycle discards the pending flag update. Release is synchronous to design intent; the first edge after release may commit.
- All outputs glitch-free with respect to clk (Flags only change on edge/reset).

## Structure
- Shared package cond_pkg: condition-code localparams (COND_EQ..COND_AL), flag index constants (FLAG_N=3, FLAG_Z=2, FLAG_C=1, FLAG_V=0), and the FlagW bit meanings (FLAGW_NZ=1, FLAGW_CV=0). The ALU decoder uses the same FlagW constants.
- One sub-module: cond_check (pure combinational Cond x Flags -> CondEx). The top holds the flag register and gating.

## Test plan
- Reset: assert reset_n=0 with FlagW=11, ALUFlags=1111 -> Flags=0000; release, Cond=0000 -> CondEx=0; Cond=0001 -> CondEx=1.
- Partial update: Cond=1110, FlagW=10, ALUFlags=1111, En=1, edge -> Flags=1100; then FlagW=01, ALUFlags=0000 -> Flags=1100 (CV already 0); then FlagW=01, ALUFlags=0011 -> Flags=1111.
- CMP: Cond=1110, RegW=1, NoWrite=1, FlagW=11, ALUFlags=0110 -> RegWrite=0; after edge, Flags=0110; next Cond=0000 -> CondEx=1, Cond=1000 -> CondEx=0 (HI needs !Z).
- Failed condition: Flags=0000, Cond=0000, PCS=RegW=MemW=1, FlagW=11, ALUFlags=1111 -> PCSrc=RegWrite=MemWrite=0; after edge Flags stays 0000.
- Signed compares: sweep all 16 Flags values x all 16 Cond values -> CondEx matches the table; spot check Flags=1000 with GE -> 0, LT -> 1, LE -> 1; Flags=1001 with GT -> 1.
- Stall: En=0, Cond=1110, FlagW=11, ALUFlags=1010, RegW=1 -> RegWrite=0, Flags unchanged over 3 edges; raise En -> RegWrite=1, Flags=1010 after the next edge.
